// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for a single-write-port 32x32 register file: round-robin
// ALU/MEM arbitration, registered write port, and per-register pending-write scoreboard.
module regfile_wb_sched #(
    parameter int unsigned PEND_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  chk_addrA,
    input  logic [4:0]  chk_addrB,
    output logic        hazard,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        overflow
);

    typedef enum logic {
        GNT_ALU,
        GNT_MEM
    } grant_e;

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    grant_e            last_grant_q, last_grant_d;
    logic              gnt_alu, gnt_mem;
    logic              acc;
    logic [4:0]        acc_addr;
    logic [31:0]       acc_data;

    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_waddr_q, rf_waddr_d;
    logic [31:0]       rf_wdata_q, rf_wdata_d;
    logic              overflow_q, overflow_d;
    logic [PEND_W-1:0] cnt_q [32];
    logic [PEND_W-1:0] cnt_d [32];

    // Round-robin pointer only moves when both requesters compete.
    always_comb begin
        gnt_alu      = 1'b0;
        gnt_mem      = 1'b0;
        last_grant_d = last_grant_q;
        if (!rst) begin
            if (alu_valid && mem_valid) begin
                if (last_grant_q == GNT_MEM) begin
                    gnt_alu      = 1'b1;
                    last_grant_d = GNT_ALU;
                end else begin
                    gnt_mem      = 1'b1;
                    last_grant_d = GNT_MEM;
                end
            end else begin
                gnt_alu = alu_valid;
                gnt_mem = mem_valid;
            end
        end
    end

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign acc       = gnt_alu | gnt_mem;
    assign acc_addr  = gnt_alu ? alu_addr : mem_addr;
    assign acc_data  = gnt_alu ? alu_data : mem_data;

    always_comb begin
        rf_we_d    = acc && (acc_addr != 5'd0);
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (acc) begin
            rf_waddr_d = acc_addr;
            rf_wdata_d = acc_data;
        end
    end

    // Saturating counters; a simultaneous effective inc and dec cancel out.
    always_comb begin
        logic hit_inc;
        logic inc;
        logic dec;
        overflow_d = overflow_q;
        cnt_d[0]   = '0;
        for (int unsigned r = 1; r < 32; r++) begin
            hit_inc  = issue_valid && (issue_addr == 5'(r));
            inc      = hit_inc && (cnt_q[r] != CNT_MAX);
            dec      = acc && (acc_addr == 5'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (hit_inc && (cnt_q[r] == CNT_MAX)) begin
                overflow_d = 1'b1;
            end
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + PEND_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_MEM;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            overflow_q   <= 1'b0;
            for (int unsigned r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            overflow_q   <= overflow_d;
            for (int unsigned r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign hazard   = (cnt_q[chk_addrA] != '0) | (cnt_q[chk_addrB] != '0);
    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed self-checking bench for regfile_wb_sched: reset, single writer,
// round-robin contention, scoreboard/hazard, saturation and mid-flight reset.
module tb_regfile_wb_sched;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  chk_addrA;
    logic [4:0]  chk_addrB;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    regfile_wb_sched #(.PEND_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_addr   (alu_addr),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .chk_addrA  (chk_addrA),
        .chk_addrB  (chk_addrB),
        .hazard     (hazard),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_waddr [4];
        logic       exp_alu_gnt [4];
        logic [4:0] ai;
        logic [4:0] mi;
        exp_waddr[0] = 5'd1;  exp_alu_gnt[0] = 1'b1;
        exp_waddr[1] = 5'd9;  exp_alu_gnt[1] = 1'b0;
        exp_waddr[2] = 5'd2;  exp_alu_gnt[2] = 1'b1;
        exp_waddr[3] = 5'd10; exp_alu_gnt[3] = 1'b0;

        rst = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2;
        issue_valid = 1'b0; issue_addr = 5'd0;
        chk_addrA = 5'd5; chk_addrB = 5'd7;

        // Reset
        step();
        chk("rst_alu_ready", 32'(alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        step();
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        rst = 1'b0;
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Single writer
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEADBEEF;
        #1;
        chk("single_alu_ready", 32'(alu_ready), 32'd1);
        chk("single_mem_ready", 32'(mem_ready), 32'd0);
        step();
        alu_valid = 1'b0;
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd3);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("single_we_drop", 32'(rf_we), 32'd0);
        chk("single_waddr_hold", 32'(rf_waddr), 32'd3);
        chk("single_wdata_hold", rf_wdata, 32'hDEADBEEF);

        // Contention: each requester advances only when accepted
        ai = 5'd1; mi = 5'd9;
        alu_valid = 1'b1; mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_addr = ai; alu_data = 32'h100 + 32'(ai);
            mem_addr = mi; mem_data = 32'h200 + 32'(mi);
            #1;
            chk("rr_alu_ready", 32'(alu_ready), 32'(exp_alu_gnt[i]));
            chk("rr_mem_ready", 32'(mem_ready), 32'(!exp_alu_gnt[i]));
            step();
            chk("rr_we", 32'(rf_we), 32'd1);
            chk("rr_waddr", 32'(rf_waddr), 32'(exp_waddr[i]));
            chk("rr_wdata", rf_wdata,
                exp_alu_gnt[i] ? 32'h100 + 32'(exp_waddr[i]) : 32'h200 + 32'(exp_waddr[i]));
            if (exp_alu_gnt[i]) ai = ai + 5'd1;
            else                mi = mi + 5'd1;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Scoreboard: two issues to x8, two writes retire them
        chk_addrA = 5'd8; chk_addrB = 5'd0;
        #1;
        chk("sb_hazard_idle", 32'(hazard), 32'd0);
        issue_valid = 1'b1; issue_addr = 5'd8;
        step();
        step();
        issue_valid = 1'b0;
        #1;
        chk("sb_hazard_cnt2_A", 32'(hazard), 32'd1);
        chk_addrA = 5'd0; chk_addrB = 5'd8;
        #1;
        chk("sb_hazard_cnt2_B", 32'(hazard), 32'd1);
        chk_addrA = 5'd8; chk_addrB = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h0800_0001;
        #1;
        chk("sb_wr1_ready", 32'(alu_ready), 32'd1);
        chk("sb_wr1_hazard_same", 32'(hazard), 32'd1);
        step();
        chk("sb_after_wr1_hazard", 32'(hazard), 32'd1);
        alu_data = 32'h0800_0002;
        #1;
        chk("sb_wr2_hazard_same", 32'(hazard), 32'd1);
        step();
        alu_valid = 1'b0;
        chk("sb_after_wr2_hazard", 32'(hazard), 32'd0);
        chk("sb_after_wr2_we", 32'(rf_we), 32'd1);
        chk("sb_after_wr2_wdata", rf_wdata, 32'h0800_0002);

        // Same-cycle issue and retire on x6 with cnt=1
        chk_addrA = 5'd6;
        issue_valid = 1'b1; issue_addr = 5'd6;
        step();
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
        step();
        issue_valid = 1'b0; mem_valid = 1'b0;
        chk("same_cyc_hazard", 32'(hazard), 32'd1);
        chk("same_cyc_we", 32'(rf_we), 32'd1);

        // Saturation: 1 -> 2 -> 3, then two issues on a full counter
        issue_valid = 1'b1; issue_addr = 5'd6;
        step();
        step();
        chk("sat_no_ovf_yet", 32'(overflow), 32'd0);
        step();
        chk("sat_ovf_set", 32'(overflow), 32'd1);
        step();
        issue_valid = 1'b0;
        step();
        chk("sat_ovf_sticky", 32'(overflow), 32'd1);

        // Drain x6: three retires needed
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h6;
        step();
        chk("drain1_hazard", 32'(hazard), 32'd1);
        step();
        chk("drain2_hazard", 32'(hazard), 32'd1);
        step();
        mem_valid = 1'b0;
        chk("drain3_hazard", 32'(hazard), 32'd0);

        // Writes and issues to x0
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h55;
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        chk("x0_ready", 32'(alu_ready), 32'd1);
        step();
        alu_valid = 1'b0; issue_valid = 1'b0;
        chk("x0_we", 32'(rf_we), 32'd0);
        chk_addrA = 5'd0; chk_addrB = 5'd0;
        #1;
        chk("x0_hazard", 32'(hazard), 32'd0);

        // Mid-flight reset with x4 pending and a MEM request held
        issue_valid = 1'b1; issue_addr = 5'd4;
        step();
        step();
        issue_valid = 1'b0;
        chk_addrA = 5'd4;
        #1;
        chk("mid_hazard_before", 32'(hazard), 32'd1);
        mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'h44;
        rst = 1'b1;
        #1;
        chk("mid_ready_in_rst", 32'(mem_ready), 32'd0);
        step();
        rst = 1'b0;
        chk("mid_hazard_after", 32'(hazard), 32'd0);
        chk("mid_we_after", 32'(rf_we), 32'd0);
        chk("mid_ovf_cleared", 32'(overflow), 32'd0);
        #1;
        chk("mid_reaccept_ready", 32'(mem_ready), 32'd1);
        step();
        mem_valid = 1'b0;
        chk("mid_reaccept_we", 32'(rf_we), 32'd1);
        chk("mid_reaccept_waddr", 32'(rf_waddr), 32'd4);
        chk("mid_reaccept_wdata", rf_wdata, 32'h44);
        chk("mid_hazard_stays0", 32'(hazard), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler for the single-write-port 32x32 register file.
- Arbitrates between two writeback requesters (ALU, MEM) with valid/ready handshakes, using round-robin under contention. Drives the register file write port from registered outputs.
- Keeps a per-register pending-write scoreboard: dispatch marks destinations, commits retire them. Produces a read-hazard flag for the decode stage's two source operands.

Parameters:
PEND_W, 2, width of each per-register pending-write counter (max outstanding writes per register = 2^PEND_W - 1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU request accepted this cycle (combinational)
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU result
mem_valid  input  1  MEM writeback request
mem_ready  output  1  MEM request accepted this cycle (combinational)
mem_addr  input  5  MEM destination register
mem_data  input  32  load data
issue_valid  input  1  dispatch of an instruction that writes issue_addr
issue_addr  input  5  destination being marked pending
chk_addrA  input  5  decode source A
chk_addrB  input  5  decode source B
hazard  output  1  either source has a pending write (combinational)
rf_we  output  1  register file write enable (registered)
rf_waddr  output  5  register file write address (registered)
rf_wdata  output  32  register file write data (registered)
overflow  output  1  sticky: issue attempted on a saturated counter

Behaviour:
- Reset state: rf_we=0, rf_waddr=0, rf_wdata=0, overflow=0, all pending counters=0, last_grant=MEM (ALU wins the first contention).
- Arbitration is combinational, with at most one grant per cycle:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant updates only on contention cycles.
  - ready is 1 only for the granted requester; a request is accepted when valid&ready.
  - Requesters hold addr/data stable while valid&!ready.
- Write port: on acceptance, the next edge registers rf_we=1 (0 if addr==0), rf_waddr=addr, rf_wdata=data. With no acceptance, rf_we=0 the next cycle while waddr/wdata hold. Latency is 1 cycle, giving throughput of 1 write/cycle.
- Register x0:
  - Writes to x0 are accepted (ready asserted normally) but never written.
  - Issue to x0 is ignored.
  - The x0 counter is constant 0, so it never causes a hazard.
- Scoreboard, per register r≠0, counter cnt[r]:
  - inc when issue_valid && issue_addr==r && cnt[r] != max.
  - dec when an accepted write has addr==r && cnt[r] != 0.
  - inc and dec in the same cycle: counter unchanged.
  - Issue while cnt[r]==max: counter unchanged, overflow set (sticky until rst).
  - Accepted write with cnt[r]==0: counter stays 0; the write still proceeds.
- hazard = (cnt[chk_addrA]!=0) | (cnt[chk_addrB]!=0), evaluated on current register state. A write accepted this cycle still shows hazard this cycle; it clears the cycle after acceptance, the same cycle rf_we is high. The regfile write lands at the following edge, so decode must not read before then. Decode adds 1 stall cycle after hazard drops, or forwards from rf_wdata when rf_we && rf_waddr matches.
- rst asserted mid-operation: all state returns to reset values at that edge. Any in-flight request is dropped, and ready is 0 while rst is high.

Test Plan:
- Reset: hold rst 2 cycles -> rf_we=0, overflow=0, hazard=0 for chk_addrA=5, chk_addrB=7; ready outputs 0 during rst.
- Single writer: alu_valid, addr=3, data=0xDEADBEEF for 1 cycle -> alu_ready=1 same cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF; cycle after that rf_we=0.
- Contention round-robin: both valid every cycle for 4 cycles (ALU addr 1..4, MEM addr 9..12) -> grants ALU, MEM, ALU, MEM; rf_waddr sequence 1, 9, 2, 10.
- Scoreboard/hazard:
  - Issue addr 8 twice -> cnt=2, hazard=1 with chk_addrA=8.
  - One write to 8 accepted -> hazard still 1.
  - Second write accepted -> hazard=0 the following cycle.
- Boundaries:
  - Issue and accept addr 6 in the same cycle with cnt=1 -> cnt stays 1.
  - Issue addr 6 four times with PEND_W=2 -> cnt=3, overflow=1.
  - Write to addr 0 -> accepted, rf_we=0.
- Reset mid-flight: cnt[4]=2 and mem_valid held -> rst for one cycle -> hazard=0 for addr 4, rf_we=0; the MEM request is re-accepted after rst deasserts.
